alu_serial_rx: RTL and testbench

// - Serial frame receiver for the ALU input link: deserialises the 99-bit sin stream
//   (8 data packets + 1 command packet, 11 bits each) into operands A, B and op.
// - Checks CRC-4, op legality and packet framing; presents one registered result per frame.
// - Sits between the sin pin and the ALU datapath. It is the DUT-side counterpart of the tester's frame builder.

---
 rtl/alu_serial_rx.sv | 152 +++++++++++++++
 tb/tb_alu_serial_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserialises the 99-bit ALU input frame (8 data packets + 1 cmd
// packet, 11 bits each) into operands A/B and op, checking framing, packet count,
// CRC-4 (x^4+x+1) and op legality. One registered result per frame.
// Optional build macro ALU_RX_TIMEOUT_EN adds an inter-packet idle timeout.
module alu_serial_rx
`ifdef ALU_RX_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  op,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op,
    output logic        timeout
);

    typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, DONE, WAIT_HI} state_t;

    state_t      state;
    logic        is_cmd;     // type bit of the packet in flight
    logic [7:0]  pay;        // payload, shifted in MSB first
    logic [2:0]  bit_cnt;
    logic [3:0]  pkt_cnt;    // data packets accepted so far in this frame
    logic [63:0] shift;      // {B, A}, bytes enter at the bottom
    logic        frame_err;  // last frame ended on a bad stop bit

    // Serial CRC-4, poly x^4+x+1, init 0, fed MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] v);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    logic crc_bad, op_bad, close, ed;

    // Decisions taken at the stop bit: does the frame close here, and with which error.
    always_comb begin
        crc_bad = crc4({shift, 1'b1, pay[6:4]}) != pay[3:0];
        op_bad  = !(pay[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101});
        close   = !sin || is_cmd || (pkt_cnt == 4'd8);
        ed      = !sin || (is_cmd ? (pkt_cnt != 4'd8) : (pkt_cnt == 4'd8));
    end

`ifdef ALU_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_cnt;
`else
    // Partial frames simply wait for more packets.
    assign timeout = 1'b0;
`endif

    // Receiver FSM with registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            is_cmd    <= 1'b0;
            pay       <= '0;
            bit_cnt   <= '0;
            pkt_cnt   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            op        <= '0;
            err_data  <= 1'b0;
            err_crc   <= 1'b0;
            err_op    <= 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
            idle_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
            timeout   <= 1'b0;
            if (state != IDLE) idle_cnt <= '0;
`endif
            case (state)
                IDLE: begin
                    if (!sin) state <= TYPE;
`ifdef ALU_RX_TIMEOUT_EN
                    // Abandon a partial frame after too long on the idle line.
                    if (sin && pkt_cnt != 4'd0) begin
                        if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                            timeout  <= 1'b1;
                            pkt_cnt  <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
`endif
                end
                TYPE: begin
                    is_cmd  <= sin;
                    bit_cnt <= '0;
                    state   <= PAYLOAD;
                end
                PAYLOAD: begin
                    pay     <= {pay[6:0], sin};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state <= STOP;
                end
                STOP: begin
                    if (close) begin
                        out_valid <= 1'b1;
                        a         <= shift[31:0];
                        b         <= shift[63:32];
                        op        <= pay[6:4];
                        err_data  <= ed;
                        err_crc   <= !ed && crc_bad;
                        err_op    <= !ed && !crc_bad && op_bad;
                        frame_err <= !sin;
                        pkt_cnt   <= '0;
                        state     <= DONE;
                    end else begin
                        shift   <= {shift[55:0], pay};
                        pkt_cnt <= pkt_cnt + 1'b1;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    // A start bit here belongs to the next frame and is accepted.
                    if (frame_err)  state <= WAIT_HI;
                    else if (!sin)  state <= TYPE;
                    else            state <= IDLE;
                end
                WAIT_HI: begin
                    if (sin) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Scoreboard bench for alu_serial_rx: stimulus pushes expected results, a monitor
// pops and compares on every out_valid. Timeout scenario only with ALU_RX_TIMEOUT_EN.
module tb_alu_serial_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic        out_valid;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        err_data, err_crc, err_op, timeout;

    alu_serial_rx dut (
        .clk(clk), .rst(rst), .sin(sin), .out_valid(out_valid),
        .a(a), .b(b), .op(op), .err_data(err_data), .err_crc(err_crc),
        .err_op(err_op), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        ed, ec, eo;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   to_seen = 0;
    int   to_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // CRC as the remainder of polynomial long division of msg*x^4 by 10011.
    function automatic logic [3:0] ref_crc(input logic [31:0] fa, input logic [31:0] fb,
                                           input logic [2:0] fop);
        logic [71:0] v;
        v = {fb, fa, 1'b1, fop, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        return v[3:0];
    endfunction

    function automatic logic legal(input logic [2:0] o);
        return (o == 3'd0) || (o == 3'd1) || (o == 3'd4) || (o == 3'd5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        sin = v;
        tick();
    endtask

    task automatic gap(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    // One 11-bit packet; sc is the cycle the stop bit is put on the line.
    task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stp, output int sc);
        drive_bit(1'b0);
        drive_bit(typ);
        for (int i = 7; i >= 0; i--) drive_bit(pl[i]);
        sc = cyc;
        drive_bit(stp);
    endtask

    task automatic push_exp(input logic [31:0] fa, input logic [31:0] fb, input logic [2:0] fop,
                            input logic ed, input logic ec, input logic eo, input int sc);
        exp_t e;
        e.a = fa; e.b = fb; e.op = fop;
        e.ed = ed; e.ec = ec; e.eo = eo;
        e.cyc = sc + 1;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [31:0] fa, input logic [31:0] fb, input logic [2:0] fop,
                              input logic [3:0] cadd, input int gmax);
        logic [63:0] d;
        logic [3:0]  c;
        logic        ec;
        int          sc;
        d = {fb, fa};
        for (int i = 0; i < 8; i++) begin
            send_pkt(1'b0, d[63 - 8*i -: 8], 1'b1, sc);
            gap($urandom_range(0, gmax));
        end
        c = ref_crc(fa, fb, fop) + cadd;
        send_pkt(1'b1, {1'b0, fop, c}, 1'b1, sc);
        ec = (cadd != 4'd0);
        push_exp(fa, fb, fop, 1'b0, ec, !ec && !legal(fop), sc);
    endtask

    // kind 0: bad stop bit, 1: cmd too early, 2: ninth data packet.
    task automatic send_err_frame(input int kind);
        int sc;
        int n;
        case (kind)
            0: begin
                n = $urandom_range(0, 8);
                for (int i = 0; i < n; i++) send_pkt(1'b0, 8'($urandom), 1'b1, sc);
                send_pkt(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, sc);
                push_exp('0, '0, '0, 1'b1, 1'b0, 1'b0, sc);
                gap($urandom_range(2, 4));
            end
            1: begin
                n = $urandom_range(0, 7);
                for (int i = 0; i < n; i++) send_pkt(1'b0, 8'($urandom), 1'b1, sc);
                send_pkt(1'b1, 8'($urandom), 1'b1, sc);
                push_exp('0, '0, '0, 1'b1, 1'b0, 1'b0, sc);
            end
            default: begin
                for (int i = 0; i < 9; i++) send_pkt(1'b0, 8'($urandom), 1'b1, sc);
                push_exp('0, '0, '0, 1'b1, 1'b0, 1'b0, sc);
            end
        endcase
    endtask

    // Monitor: every out_valid must match the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                chk("err_data", 64'(err_data), 64'(e.ed));
                chk("err_crc", 64'(err_crc), 64'(e.ec));
                chk("err_op", 64'(err_op), 64'(e.eo));
                if (!e.ed) begin
                    chk("a", 64'(a), 64'(e.a));
                    chk("b", 64'(b), 64'(e.b));
                    chk("op", 64'(op), 64'(e.op));
                end
            end
        end
        if (!rst && timeout) to_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, queue %0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int kind;
        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_a", 64'(a), 0);
        chk("rst_b", 64'(b), 0);
        chk("rst_op", 64'(op), 0);
        chk("rst_errs", 64'({err_data, err_crc, err_op}), 0);
        chk("rst_timeout", 64'(timeout), 0);
        tick();
        rst = 1'b0;
        gap(3);

        // Directed cases.
        send_frame(32'h1, 32'h2, 3'b100, 4'd0, 0);            gap(2);
        send_frame(32'h1, 32'h2, 3'b100, 4'd1, 1);            gap(2);
        send_frame('1, '1, 3'b110, 4'd0, 0);                  gap(2);
        for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'($urandom), 1'b1, sc);
        send_pkt(1'b1, 8'h40, 1'b1, sc);
        push_exp('0, '0, '0, 1'b1, 1'b0, 1'b0, sc);
        gap(1);
        send_frame(32'hDEAD_BEEF, 32'h0123_4567, 3'b101, 4'd0, 2); gap(2);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'($urandom), 1'b1, sc);
        rst = 1'b1;
        tick();
        chk("rst_mid_a", 64'(a), 0);
        chk("rst_mid_b", 64'(b), 0);
        tick();
        rst = 1'b0;
        gap(2);
        send_frame('0, '0, 3'b000, 4'd0, 0);                  gap(2);

`ifdef ALU_RX_TIMEOUT_EN
        for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'($urandom), 1'b1, sc);
        gap(64);
        to_exp++;
        gap(4);
        send_frame(32'h5, 32'h6, 3'b001, 4'd0, 0);            gap(2);
`endif

        // Randomised frames; gap 0 after a frame exercises back-to-back start.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 8);
            if (kind < 6)
                send_frame($urandom, $urandom, 3'($urandom_range(0, 7)),
                           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0, 3);
            else
                send_err_frame(kind - 6);
            gap($urandom_range(0, 3));
        end

        gap(4);
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        chk("queue_drained", 64'(q.size()), 0);
        chk("timeout_pulses", 64'(to_seen), 64'(to_exp));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
